dfe_tap_adapt_ctrl: RTL and testbench

Sign-sign LMS adaptation controller for the two-tap decision feedback equalizer. It watches the recovered decision `data` and an error-slicer sign `err` on the receive clock, correlates the error against the two most recent past decisions over fixed windows, and steps the two DFE tap weight codes up or down. The tap codes are held in registers and drive the DFE feedback FIR tap weights through a digital-to-real conversion outside this block. The block also reports convergence.

---
 rtl/dfe_tap_adapt_ctrl.sv | 157 +++++++++++++++
 tb/tb_dfe_tap_adapt_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dfe_tap_adapt_ctrl.sv
// Sign-sign LMS adaptation controller for a two-tap DFE: correlates the error sign
// against the two previous decisions over fixed windows and steps the tap codes.
module dfe_tap_adapt_ctrl #(
    parameter int W          = 8,
    parameter int INIT0      = 0,
    parameter int INIT1      = 0,
    parameter int WMIN       = -128,
    parameter int WMAX       = 127,
    parameter int ACC_W      = 10,
    parameter int ACC_LEN    = 256,
    parameter int THR        = 16,
    parameter int STEP       = 1,
    parameter int SETTLE_CYC = 4,
    parameter int HOLD_WIN   = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic                freeze,
    input  logic                data,
    input  logic                err,
    output logic signed [W-1:0] wtap0,
    output logic signed [W-1:0] wtap1,
    output logic                upd,
    output logic                converged,
    output logic                busy
);

    localparam int CNT_W = $clog2(ACC_LEN + SETTLE_CYC + 1);
    localparam int HW_W  = $clog2(HOLD_WIN + 1);

    localparam logic signed [W:0]       STEP_X = (W+1)'(STEP);
    localparam logic signed [W:0]       WMAX_X = (W+1)'(WMAX);
    localparam logic signed [W:0]       WMIN_X = (W+1)'(WMIN);
    localparam logic signed [ACC_W-1:0] THR_A  = ACC_W'(THR);
    localparam logic signed [ACC_W-1:0] NTHR_A = ACC_W'(-THR);
    localparam logic signed [ACC_W-1:0] ONE_A  = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] MONE_A = ACC_W'(-1);
    localparam logic [CNT_W-1:0]        SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]        ACC_LAST    = CNT_W'(ACC_LEN - 1);
    localparam logic [HW_W-1:0]         HW_MAX      = HW_W'(HOLD_WIN);
    localparam logic [HW_W-1:0]         HW_M1       = HW_W'(HOLD_WIN - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, UPDATE} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q;
    logic [HW_W-1:0]           hold_q;
    logic signed [ACC_W-1:0]   acc0_q, acc1_q;
    logic                      d1_q, d2_q;
    logic                      p0, p1, last_settle, last_acc, changed;
    logic signed [W-1:0]       wn0, wn1;

    // Sum is formed one bit wider than the tap so the limit test cannot wrap.
    function automatic logic signed [W-1:0] adapt_tap(input logic signed [W-1:0] w,
                                                     input logic signed [ACC_W-1:0] acc);
        logic signed [W:0] s;
        s = {w[W-1], w};
        if (acc >= THR_A) begin
            s = s + STEP_X;
            if (s > WMAX_X) s = WMAX_X;
        end else if (acc <= NTHR_A) begin
            s = s - STEP_X;
            if (s < WMIN_X) s = WMIN_X;
        end
        return s[W-1:0];
    endfunction

    assign p0          = ~(err ^ d1_q);
    assign p1          = ~(err ^ d2_q);
    assign last_settle = (cnt_q == SETTLE_LAST);
    assign last_acc    = (cnt_q == ACC_LAST);
    assign wn0         = adapt_tap(wtap0, acc0_q);
    assign wn1         = adapt_tap(wtap1, acc1_q);
    assign changed     = (wn0 != wtap0) || (wn1 != wtap1);
    assign busy        = (state_q != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else if (!freeze) begin
            case (state_q)
                IDLE:    state_d = SETTLE;
                SETTLE:  if (last_settle) state_d = ACCUM;
                ACCUM:   if (last_acc) state_d = UPDATE;
                UPDATE:  state_d = ACCUM;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wtap0     <= W'(INIT0);
            wtap1     <= W'(INIT1);
            upd       <= 1'b0;
            converged <= 1'b0;
            cnt_q     <= '0;
            hold_q    <= '0;
            acc0_q    <= '0;
            acc1_q    <= '0;
            d1_q      <= 1'b0;
            d2_q      <= 1'b0;
        end else begin
            upd <= 1'b0;
            if (!en) begin
                cnt_q     <= '0;
                hold_q    <= '0;
                acc0_q    <= '0;
                acc1_q    <= '0;
                converged <= 1'b0;
            end else if (!freeze) begin
                d2_q <= d1_q;
                d1_q <= data;
                case (state_q)
                    IDLE: cnt_q <= '0;
                    SETTLE: begin
                        if (last_settle) begin
                            cnt_q  <= '0;
                            acc0_q <= '0;
                            acc1_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ACCUM: begin
                        acc0_q <= acc0_q + (p0 ? ONE_A : MONE_A);
                        acc1_q <= acc1_q + (p1 ? ONE_A : MONE_A);
                        cnt_q  <= last_acc ? '0 : cnt_q + CNT_W'(1);
                    end
                    UPDATE: begin
                        wtap0  <= wn0;
                        wtap1  <= wn1;
                        acc0_q <= '0;
                        acc1_q <= '0;
                        upd    <= changed;
                        if (changed) begin
                            hold_q    <= '0;
                            converged <= 1'b0;
                        end else begin
                            if (hold_q != HW_MAX) hold_q <= hold_q + HW_W'(1);
                            if (hold_q >= HW_M1) converged <= 1'b1;
                        end
                    end
                    default: cnt_q <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dfe_tap_adapt_ctrl.sv
// Directed bench for dfe_tap_adapt_ctrl: PRBS7 decisions with error signs derived
// from delayed decisions, so each window's correlation is known in advance.
module tb_dfe_tap_adapt_ctrl;

    logic                clk = 1'b0;
    logic                rstn, en, freeze, data, err;
    logic signed [7:0]   wtap0, wtap1;
    logic                upd, converged, busy;

    int       tests = 0;
    int       fails = 0;
    logic [6:0] lfsr = 7'h7F;
    logic     h1 = 1'b0;
    logic     h2 = 1'b0;
    int       mode = 1;

    dfe_tap_adapt_ctrl #(.W(8), .INIT0(5), .INIT1(-3)) dut (
        .clk(clk), .rstn(rstn), .en(en), .freeze(freeze), .data(data), .err(err),
        .wtap0(wtap0), .wtap1(wtap1), .upd(upd), .converged(converged), .busy(busy)
    );

    always #5 clk = ~clk;

    // mode 0: err = d[n] ; mode 1: err = d[n-1] ; mode 2: err = ~d[n-2]
    function automatic logic calc_err();
        case (mode)
            0:       return data;
            1:       return h1;
            default: return ~h2;
        endcase
    endfunction

    // The PRBS and bench history advance only on edges the DUT consumes a symbol.
    task automatic step();
        @(posedge clk);
        #1;
        if (rstn && en && !freeze) begin
            h2   = h1;
            h1   = data;
            lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
            data = lfsr[6];
        end
        err = calc_err();
    endtask

    task automatic wait_upd(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!upd && n < limit);
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b0; freeze = 1'b0; data = lfsr[6]; err = calc_err();
        step(); step();
        tests++; if (wtap0 !== 8'sd5) begin fails++; $display("FAIL rst_wtap0: got %0d expected 5", wtap0); end
        tests++; if (wtap1 !== -8'sd3) begin fails++; $display("FAIL rst_wtap1: got %0d expected -3", wtap1); end
        tests++; if (upd !== 1'b0) begin fails++; $display("FAIL rst_upd: got %b expected 0", upd); end
        tests++; if (converged !== 1'b0) begin fails++; $display("FAIL rst_conv: got %b expected 0", converged); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", busy); end
        rstn = 1'b1;
        step(); step();
        tests++; if (wtap0 !== 8'sd5) begin fails++; $display("FAIL post_rst_wtap0: got %0d expected 5", wtap0); end
        tests++; if (wtap1 !== -8'sd3) begin fails++; $display("FAIL post_rst_wtap1: got %0d expected -3", wtap1); end
        tests++; if (upd !== 1'b0) begin fails++; $display("FAIL post_rst_upd: got %b expected 0", upd); end
        tests++; if (converged !== 1'b0) begin fails++; $display("FAIL post_rst_conv: got %b expected 0", converged); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL post_rst_busy: got %b expected 0", busy); end
    endtask

    task automatic test_tap0_up();
        int n;
        mode = 1; err = calc_err(); en = 1'b1;
        wait_upd(600, n);
        tests++; if (n !== 262) begin fails++; $display("FAIL tap0_first_latency: got %0d expected 262", n); end
        tests++; if (wtap0 !== 8'sd6) begin fails++; $display("FAIL tap0_first: got %0d expected 6", wtap0); end
        tests++; if (wtap1 !== -8'sd3) begin fails++; $display("FAIL tap0_w1_hold: got %0d expected -3", wtap1); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL tap0_busy: got %b expected 1", busy); end
        step();
        tests++; if (upd !== 1'b0) begin fails++; $display("FAIL tap0_upd_pulse: got %b expected 0", upd); end
        wait_upd(600, n);
        tests++; if (n !== 256) begin fails++; $display("FAIL tap0_period: got %0d expected 256", n); end
        tests++; if (wtap0 !== 8'sd7) begin fails++; $display("FAIL tap0_second: got %0d expected 7", wtap0); end
    endtask

    task automatic test_tap1_down();
        int n, nu;
        logic c_before;
        en = 1'b0;
        step();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL en_drop_busy: got %b expected 0", busy); end
        mode = 2; err = calc_err(); en = 1'b1;
        n = 0; nu = 0;
        while (wtap1 != -128 && n < 33000) begin
            step();
            n++;
            if (upd) nu++;
        end
        tests++; if (n !== 32130) begin fails++; $display("FAIL tap1_sat_cycles: got %0d expected 32130", n); end
        tests++; if (nu !== 125) begin fails++; $display("FAIL tap1_upd_count: got %0d expected 125", nu); end
        tests++; if (wtap0 !== 8'sd7) begin fails++; $display("FAIL tap1_w0_hold: got %0d expected 7", wtap0); end
        nu = 0; c_before = 1'b1;
        for (int i = 1; i <= 1028; i++) begin
            step();
            if (upd) nu++;
            if (i == 1027) c_before = converged;
        end
        tests++; if (nu !== 0) begin fails++; $display("FAIL sat_no_upd: got %0d expected 0", nu); end
        tests++; if (c_before !== 1'b0) begin fails++; $display("FAIL sat_conv_early: got %b expected 0", c_before); end
        tests++; if (converged !== 1'b1) begin fails++; $display("FAIL sat_conv: got %b expected 1", converged); end
        tests++; if (wtap1 !== -8'sd128) begin fails++; $display("FAIL sat_w1: got %0d expected -128", wtap1); end
    endtask

    task automatic test_converge();
        int nu;
        logic c_before;
        en = 1'b0;
        step();
        tests++; if (converged !== 1'b0) begin fails++; $display("FAIL en_drop_conv: got %b expected 0", converged); end
        mode = 0; err = calc_err(); en = 1'b1;
        nu = 0; c_before = 1'b1;
        for (int i = 1; i <= 1033; i++) begin
            step();
            if (upd) nu++;
            if (i == 1032) c_before = converged;
        end
        tests++; if (nu !== 0) begin fails++; $display("FAIL prbs_no_upd: got %0d expected 0", nu); end
        tests++; if (c_before !== 1'b0) begin fails++; $display("FAIL prbs_conv_early: got %b expected 0", c_before); end
        tests++; if (converged !== 1'b1) begin fails++; $display("FAIL prbs_conv: got %b expected 1", converged); end
        tests++; if (wtap0 !== 8'sd7) begin fails++; $display("FAIL prbs_w0: got %0d expected 7", wtap0); end
        tests++; if (wtap1 !== -8'sd128) begin fails++; $display("FAIL prbs_w1: got %0d expected -128", wtap1); end
    endtask

    task automatic test_freeze();
        int n, nu;
        en = 1'b0;
        step();
        mode = 1; err = calc_err(); en = 1'b1;
        for (int i = 0; i < 100; i++) step();
        freeze = 1'b1;
        nu = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (upd) nu++;
        end
        tests++; if (nu !== 0) begin fails++; $display("FAIL frz_upd: got %0d expected 0", nu); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL frz_busy: got %b expected 1", busy); end
        freeze = 1'b0;
        wait_upd(600, n);
        tests++; if (n !== 162) begin fails++; $display("FAIL frz_window: got %0d expected 162", n); end
        tests++; if (wtap0 !== 8'sd8) begin fails++; $display("FAIL frz_w0: got %0d expected 8", wtap0); end
        tests++; if (wtap1 !== -8'sd128) begin fails++; $display("FAIL frz_w1: got %0d expected -128", wtap1); end
    endtask

    task automatic test_en_drop_update();
        int n;
        en = 1'b0;
        step();
        en = 1'b1;
        for (int i = 0; i < 261; i++) step();
        tests++; if (upd !== 1'b0) begin fails++; $display("FAIL pre_upd_state: got %b expected 0", upd); end
        en = 1'b0;
        step();
        tests++; if (upd !== 1'b0) begin fails++; $display("FAIL endrop_upd: got %b expected 0", upd); end
        tests++; if (wtap0 !== 8'sd8) begin fails++; $display("FAIL endrop_w0: got %0d expected 8", wtap0); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL endrop_idle: got %b expected 0", busy); end
        en = 1'b1;
        wait_upd(600, n);
        tests++; if (n !== 262) begin fails++; $display("FAIL reen_latency: got %0d expected 262", n); end
        tests++; if (wtap0 !== 8'sd9) begin fails++; $display("FAIL reen_w0: got %0d expected 9", wtap0); end
    endtask

    initial begin
        test_reset();
        test_tap0_up();
        test_tap1_down();
        test_converge();
        test_freeze();
        test_en_drop_update();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
